// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit.
//   XLEN        address / PC width
//   ILEN        instruction width
//   INST_NOP    instruction presented while the buffer is empty (addi x0, x0, 0)
//   ifu_state_t fetch FSM states
package ifu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic [0:0] {
    IFU_RUN   = 1'b0,
    IFU_DRAIN = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with asynchronous active-high reset and a synchronous flush.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset, empties the FIFO
//   flush_i      empties the FIFO at the next edge; wins over push/pop
//   push_i       write push_data_i (ignored when full)
//   push_data_i  entry to write
//   pop_i        drop the head entry (ignored when empty)
//   head_o       head entry, valid while count_o != 0
//   count_o      number of stored entries
// Depth must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [AddrW:0]   count_o
);

  localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != DepthCnt);
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + (AddrW + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: decoupled fetch stage. Issues sequential word-aligned fetches,
// buffers returned instructions with their PCs and hands them to the core via valid/ready.
// A redirect flushes everything buffered and drains responses still in flight.
// Ports:
//   clk, reset                        clock and asynchronous active-high reset
//   redirect_valid, redirect_pc       taken branch: flush and refetch from redirect_pc
//   imem_req_valid/addr/ready         fetch request channel
//   imem_rsp_valid/inst               in-order response channel, latency >= 1
//   inst_valid/inst/inst_pc/inst_ready  instruction hand-off to the core
//   stat_fetched, stat_flushed        saturating counters, only with IFU_STATS_EN defined
// Build option: define IFU_STATS_EN to add the statistics counters and ports.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_inst,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef IFU_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthLim = DEPTH[CntW:0];

  ifu_state_t           state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]      outstanding, outstanding_d;
  logic [CntW-1:0]      pend_count, buf_count;
  logic [XLEN-1:0]      pend_pc;
  logic [XLEN+ILEN-1:0] buf_head;
  logic                 req_fire, rsp_take, inst_fire, credit_ok;
  logic                 unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign inst_fire = inst_valid && inst_ready;
  // A response is kept only in IFU_RUN and only if no redirect flushes it this cycle.
  assign rsp_take  = imem_rsp_valid && (state_q == IFU_RUN) && !redirect_valid;

  // The pending queue is flushed on redirect and no requests issue while draining, so
  // in-flight requests are exactly those queued plus those still to be dropped.
  assign outstanding   = pend_count + drop_cnt_q;
  assign outstanding_d = outstanding + CntW'(req_fire) - CntW'(imem_rsp_valid);
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, buf_count}) < DepthLim;

  ifu_fifo #(
    .Width (XLEN),
    .Depth (DEPTH)
  ) u_pend_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (redirect_valid),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_take),
    .head_o      (pend_pc),
    .count_o     (pend_count)
  );

  ifu_fifo #(
    .Width (XLEN + ILEN),
    .Depth (DEPTH)
  ) u_inst_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (redirect_valid),
    .push_i      (rsp_take),
    .push_data_i ({pend_pc, imem_rsp_inst}),
    .pop_i       (inst_fire),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IFU_RUN;
      drop_cnt_q <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? IFU_DRAIN : IFU_RUN;
    end else if ((state_q == IFU_DRAIN) && imem_rsp_valid) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
      if (drop_cnt_d == '0) state_d = IFU_RUN;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  // Outputs. Gating with reset keeps the request low while reset is held.
  always_comb begin
    imem_req_valid = !reset && (state_q == IFU_RUN) && credit_ok;
    imem_req_addr  = fetch_pc_q;
    inst_valid     = (buf_count != '0);
    inst           = inst_valid ? buf_head[ILEN-1:0] : INST_NOP;
    inst_pc        = inst_valid ? buf_head[XLEN+ILEN-1:ILEN] : '0;
  end

`ifdef IFU_STATS_EN
  logic [31:0]     stat_fetched_q, stat_flushed_q;
  logic [CntW-1:0] flushed_buf;
  logic            rsp_drop;
  logic [32:0]     flushed_sum;

  // Entries left behind by a redirect (the head transferring this cycle is not lost).
  assign flushed_buf = redirect_valid ? (buf_count - CntW'(inst_fire)) : '0;
  assign rsp_drop    = imem_rsp_valid && ((state_q == IFU_DRAIN) || redirect_valid);
  assign flushed_sum = {1'b0, stat_flushed_q} + 33'(flushed_buf) + 33'(rsp_drop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (inst_fire && (stat_fetched_q != 32'hFFFFFFFF)) stat_fetched_q <= stat_fetched_q + 32'd1;
      stat_flushed_q <= flushed_sum[32] ? 32'hFFFFFFFF : flushed_sum[31:0];
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an in-order memory of configurable latency.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_inst = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef IFU_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  instruction_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_inst  (imem_rsp_inst),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IFU_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;

  typedef struct {
    int unsigned due;
    logic [63:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  logic [63:0] req_log[$];
  logic [63:0] del_pc[$];
  logic [31:0] del_inst[$];
  int unsigned del_cyc[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return 32'hA000_0000 ^ a[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model and transfer logging, evaluated with pre-edge values.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
    end else begin
      if (imem_rsp_valid && (mq.size() > 0)) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{due: cyc + lat, addr: imem_req_addr});
        req_log.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) begin
        del_pc.push_back(inst_pc);
        del_inst.push_back(inst);
        del_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if ((mq.size() > 0) && (mq[0].due <= cyc + 1)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_inst  = inst_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = '0;
    end
  end

  task automatic reset_cycles();
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, imem_req_valid, 0);
    check_eq({tag, "_req_addr"}, imem_req_addr, 64'h0);
    check_eq({tag, "_inst_valid"}, inst_valid, 0);
    check_eq({tag, "_inst"}, inst, 64'h13);
    check_eq({tag, "_inst_pc"}, inst_pc, 64'h0);
`ifdef IFU_STATS_EN
    check_eq({tag, "_stat_flushed"}, stat_flushed, 0);
`endif
  endtask

  initial begin
    int unsigned br, bd, idx, ri;
    bit found;

    #2;
    check_reset_outputs("rst");

    // 1-cycle memory, ready core: one instruction per cycle.
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    reset_cycles();
    br = req_log.size(); bd = del_pc.size();
    reset = 1'b0;
    #1;
    check_eq("t1_first_req_valid", imem_req_valid, 1);
    check_eq("t1_first_req_addr", imem_req_addr, 64'h0);
    repeat (10) @(negedge clk);
    check_eq("t1_req0", req_log[br], 64'h0);
    check_eq("t1_req1", req_log[br+1], 64'h4);
    check_eq("t1_req2", req_log[br+2], 64'h8);
    check_eq("t1_pc0", del_pc[bd], 64'h0);
    check_eq("t1_pc1", del_pc[bd+1], 64'h4);
    check_eq("t1_pc2", del_pc[bd+2], 64'h8);
    check_eq("t1_inst0", del_inst[bd], 64'hA000_0000);
    check_eq("t1_inst2", del_inst[bd+2], 64'hA000_0008);
    check_eq("t1_gap01", del_cyc[bd+1] - del_cyc[bd], 1);
    check_eq("t1_gap12", del_cyc[bd+2] - del_cyc[bd+1], 1);

    // Stalled core: credit limit stops fetch after DEPTH requests.
    inst_ready = 1'b0;
    reset_cycles();
    br = req_log.size(); bd = del_pc.size();
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t2_req_count", req_log.size() - br, 4);
    check_eq("t2_req_valid_low", imem_req_valid, 0);
    check_eq("t2_req_addr", imem_req_addr, 64'h10);
    check_eq("t2_inst_valid", inst_valid, 1);
    check_eq("t2_head_pc", inst_pc, 64'h0);
    check_eq("t2_head_inst", inst, 64'hA000_0000);
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t2_resume_addr", req_log[br+4], 64'h10);
    check_eq("t2_first_del", del_pc[bd], 64'h0);

    // Memory back-pressure at 0x8: address held, fetch_pc not advanced.
    reset_cycles();
    br = req_log.size();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    #1;
    check_eq("t3_hold_addr0", imem_req_addr, 64'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_hold_addr", imem_req_addr, 64'h8);
      check_eq("t3_hold_valid", imem_req_valid, 1);
    end
    imem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t3_req_count_at_stall", req_log[br+1], 64'h4);
    check_eq("t3_req_after_stall", req_log[br+2], 64'h8);
    check_eq("t3_req_next", req_log[br+3], 64'hC);

    // 3-cycle memory, redirect to 0x103 with two requests in flight.
    lat = 3;
    reset_cycles();
    br = req_log.size(); bd = del_pc.size();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    check_eq("t4_drain_valid", imem_req_valid, 0);
    check_eq("t4_redirect_addr", imem_req_addr, 64'h100);
    @(negedge clk);
    check_eq("t4_drain_valid2", imem_req_valid, 0);
    @(negedge clk);
    check_eq("t4_resume_valid", imem_req_valid, 1);
    check_eq("t4_resume_addr", imem_req_addr, 64'h100);
    repeat (8) @(negedge clk);
    check_eq("t4_req_count_pre", req_log[br+1], 64'h4);
    check_eq("t4_req_after", req_log[br+2], 64'h100);
    check_eq("t4_first_pc", del_pc[bd], 64'h100);
    check_eq("t4_first_inst", del_inst[bd], 64'hA000_0100);

    // Redirect together with a head transfer at 0x20 and a request accept.
    lat = 1;
    reset_cycles();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (inst_valid && (inst_pc == 64'h20)) found = 1'b1;
    end
    check_eq("t5_reach_head20", found, 1);
    check_eq("t5_accept_same_cycle", imem_req_valid, 1);
    check_eq("t5_accept_addr", imem_req_addr, 64'h28);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    idx = del_pc.size() - 1;
    ri  = req_log.size();
    check_eq("t5_buf_empty", inst_valid, 0);
    check_eq("t5_drain_valid", imem_req_valid, 0);
    check_eq("t5_delivered20", del_pc[idx], 64'h20);
    check_eq("t5_last_req", req_log[ri-1], 64'h28);
    repeat (6) @(negedge clk);
    check_eq("t5_next_req", req_log[ri], 64'h200);
    check_eq("t5_next_del", del_pc[idx+1], 64'h200);

    // Asynchronous reset while draining.
    lat = 3;
    reset_cycles();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h300;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("t6_in_drain", imem_req_valid, 0);
    check_eq("t6_addr_pre", imem_req_addr, 64'h300);
`ifdef IFU_STATS_EN
    check_eq("t6_stat_pre", stat_flushed, 1);
`endif
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    lat = 1;
    repeat (2) @(negedge clk);
    bd = del_pc.size();
    reset = 1'b0;
    #1;
    check_eq("t6_restart_valid", imem_req_valid, 1);
    check_eq("t6_restart_addr", imem_req_addr, 64'h0);
    repeat (5) @(negedge clk);
    check_eq("t6_first_del", del_pc[bd], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
